// File: rtl/mips_pkg.sv
// Shared ALU_OP encodings and MULT/DIV sequencer state type.
package mips_pkg;

    localparam int unsigned ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_OP_MULT = 5'b00110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // True for the two encodings that launch a multi-cycle operation.
    function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on magnitudes.
module muldiv_core #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              op_div,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] acc_hi_nxt_c,
    output logic [DATA_W-1:0] acc_lo_nxt_c
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              ge;

    // MULT: {acc_hi,acc_lo} is product/multiplier; DIV: acc_hi remainder, acc_lo dividend->quotient.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : {(DATA_W+1){1'b0}});
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        ge      = (shifted >= {1'b0, m});
        // Difference is below the divisor whenever it is used, so DATA_W bits suffice.
        diff    = shifted[DATA_W-1:0] - m;
        if (op_div) begin
            acc_hi_nxt_c = ge ? diff : shifted[DATA_W-1:0];
            acc_lo_nxt_c = {acc_lo[DATA_W-2:0], ge};
        end else begin
            acc_hi_nxt_c = sum[DATA_W:1];
            acc_lo_nxt_c = {sum[0], acc_lo[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV unit holding the architectural HI/LO registers.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] ALU_OP,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic                flush,
    input  logic                hi_we,
    input  logic                lo_we,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    md_state_t           state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   acc_hi_q, acc_lo_q, m_q;
    logic [DATA_W-1:0]   acc_hi_step, acc_lo_step;
    logic                op_div_q, neg_quot_q, neg_rem_q, div_zero_q;
    logic                accept, fix;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] prod_mag, prod_signed;
    logic [DATA_W-1:0]   res_hi, res_lo;

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .op_div       (op_div_q),
        .acc_hi       (acc_hi_q),
        .acc_lo       (acc_lo_q),
        .m            (m_q),
        .acc_hi_nxt_c (acc_hi_step),
        .acc_lo_nxt_c (acc_lo_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state logic; flush overrides everything, including a same-cycle start.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        fix       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_muldiv(ALU_OP)) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = FIX;
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            fix       = 1'b0;
        end
    end

    // Operand magnitudes; INT_MIN maps onto itself as an unsigned magnitude.
    always_comb begin
        a_mag = op_a[DATA_W-1] ? DATA_W'(-op_a) : op_a;
        b_mag = op_b[DATA_W-1] ? DATA_W'(-op_b) : op_b;
    end

    // Sign fix-up of the magnitude results.
    always_comb begin
        prod_mag    = {acc_hi_q, acc_lo_q};
        prod_signed = neg_quot_q ? (2*DATA_W)'(-prod_mag) : prod_mag;
        if (op_div_q) begin
            res_lo = neg_quot_q ? DATA_W'(-acc_lo_q) : acc_lo_q;
            res_hi = neg_rem_q  ? DATA_W'(-acc_hi_q) : acc_hi_q;
            if (div_zero_q) res_lo = {DATA_W{1'b1}};
        end else begin
            res_hi = prod_signed[2*DATA_W-1:DATA_W];
            res_lo = prod_signed[DATA_W-1:0];
        end
    end

    // Iteration counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            m_q        <= '0;
            op_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= a_mag;
            m_q        <= b_mag;
            op_div_q   <= (ALU_OP == ALU_OP_DIV);
            neg_quot_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            neg_rem_q  <= op_a[DATA_W-1];
            div_zero_q <= (ALU_OP == ALU_OP_DIV) && (op_b == '0);
        end else if (state_q == CALC && !flush) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            acc_hi_q <= acc_hi_step;
            acc_lo_q <= acc_lo_step;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= fix;
        end
    end

    // HI/LO: result write on FIX, MTHI/MTLO only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state_q == IDLE) begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests  = 0;
    int failed = 0;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ALU_OP  (alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request in the current cycle (cycle 0); returns just after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        alu_op = 5'b00000;
        op_a   = 32'h1234_5678;
        op_b   = 32'h9ABC_DEF0;
    endtask

    // Walk cycles first..33 expecting busy, then the done cycle and the cycle after.
    task automatic track(input string tag, input int first, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
        int good = 0;
        for (int k = first; k <= 33; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b0) good++;
        end
        check({tag, " busy window"}, 64'(good), 64'(34 - first));
        @(negedge clk);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy@done"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        @(negedge clk);
        check({tag, " done pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_op  = 5'b00000;
        op_a    = '0;
        op_b    = '0;
        flush   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;

        // Non-MULT/DIV op with start must not launch.
        issue(5'b00000, 32'd3, 32'd4);
        @(negedge clk);
        check("other op ignored", {63'd0, busy}, 64'd0);

        // MTHI, MTLO, then both together.
        hi_we = 1'b1; wr_data = 32'h1111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h2222;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h1111);
        check("mtlo", {32'd0, lo}, 64'h2222);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h3333;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi+mtlo hi", {32'd0, hi}, 64'h3333);
        check("mthi+mtlo lo", {32'd0, lo}, 64'h3333);

        // Start together with MTHI: write lands first, FIX overwrites.
        @(negedge clk);
        start = 1'b1; alu_op = ALU_OP_MULT; op_a = 32'd2; op_b = 32'd5;
        hi_we = 1'b1; wr_data = 32'hAAAA;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; alu_op = 5'b00000;
        check("start+mthi write lands", {32'd0, hi}, 64'hAAAA);
        track("mult 2x5", 1, 32'h0, 32'd10);

        issue(ALU_OP_MULT, 32'd7, 32'hFFFF_FFFD);
        track("mult 7x-3", 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        issue(ALU_OP_MULT, 32'h8000_0000, 32'h8000_0000);
        track("mult min x min", 1, 32'h4000_0000, 32'h0);

        issue(ALU_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track("mult -1x-1", 1, 32'h0, 32'h1);

        issue(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        track("div -7/2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(ALU_OP_DIV, 32'd7, 32'hFFFF_FFFE);
        track("div 7/-2", 1, 32'h1, 32'hFFFF_FFFD);

        issue(ALU_OP_DIV, 32'd5, 32'd0);
        track("div 5/0", 1, 32'd5, 32'hFFFF_FFFF);

        issue(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        track("div min/-1", 1, 32'h0, 32'h8000_0000);

        // Flush in cycle 10 of DIV 100/7; restart MULT in cycle 12.
        issue(ALU_OP_DIV, 32'd100, 32'd7);
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        if (done !== 1'b0) seen++;
        check("flush busy low c11", {63'd0, busy}, 64'd0);
        check("flush no done", 64'(seen), 64'd0);
        check("flush hi kept", {32'd0, hi}, 64'h0);
        check("flush lo kept", {32'd0, lo}, 64'h8000_0000);
        issue(ALU_OP_MULT, 32'd6, 32'd7);
        track("mult after flush", 1, 32'h0, 32'd42);

        // Start DIV and MTHI while MULT 3x4 is busy (cycle 5): both ignored.
        issue(ALU_OP_MULT, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        @(negedge clk);
        start = 1'b1; alu_op = ALU_OP_DIV; op_a = 32'd9; op_b = 32'd2;
        hi_we = 1'b1; wr_data = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0; alu_op = 5'b00000; hi_we = 1'b0;
        check("mthi ignored while busy", {32'd0, hi}, 64'h0);
        track("mult 3x4 busy starts", 6, 32'h0, 32'd12);

        // Reset in cycle 20 of an op.
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("preload lo", {32'd0, lo}, 64'h5A5A);
        issue(ALU_OP_MULT, 32'd9, 32'd9);
        repeat (19) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-op reset busy", {63'd0, busy}, 64'd0);
        check("mid-op reset done", {63'd0, done}, 64'd0);
        check("mid-op reset hi", {32'd0, hi}, 64'd0);
        check("mid-op reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("no activity after reset", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
